vram_arb: RTL and testbench

Parametrised single-clock video RAM with an arbitrated CPU port and a fixed-latency display port. Sits between the bus-side VGA register slave and the scan-out timing generator. The display read path always wins, and CPU accesses stall with a req/ack handshake. CPU writes carry per-colour-channel lane masks, and an optional hardware fill engine clears the frame.

---
 rtl/vram_pkg.sv | 31 +++
 rtl/vram_mem.sv | 52 +++++
 rtl/vram_arb.sv | 200 ++++++++++++++++++++
 tb/tb_vram_arb.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vram_pkg
// Brief   : Shared defaults, fill-state encoding and lane-mask helper for VRAM.
// Revision: 1.0
// ============================================================================
package vram_pkg;

  localparam int VRAM_DATA_W = 12;
  localparam int VRAM_CH_W   = 4;
  localparam int VRAM_ADDR_W = 19;
  localparam int VRAM_DEPTH  = 307200;
  localparam int VRAM_NCH    = VRAM_DATA_W / VRAM_CH_W;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  // Widen a per-channel enable into a per-bit enable at the default pixel format
  function automatic logic [VRAM_DATA_W-1:0] lane_mask(input logic [VRAM_NCH-1:0] m);
    logic [VRAM_DATA_W-1:0] bm;
    bm = '0;
    for (int i = 0; i < VRAM_NCH; i++) begin
      bm[i*VRAM_CH_W +: VRAM_CH_W] = {VRAM_CH_W{m[i]}};
    end
    return bm;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vram_mem.sv
`default_nettype none
// ============================================================================
// Module  : vram_mem
// Brief   : Single-port pixel array with per-channel write enables, registered read.
// Revision: 1.0
// ============================================================================
module vram_mem
  import vram_pkg::*;
#(
  parameter int DATA_W = VRAM_DATA_W,
  parameter int CH_W   = VRAM_CH_W,
  parameter int DEPTH  = VRAM_DEPTH,
  parameter int IDX_W  = $clog2(VRAM_DEPTH)
) (
  input  logic                     clk,
  input  logic                     re,
  input  logic [DATA_W/CH_W-1:0]   we,
  input  logic [IDX_W-1:0]         addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  localparam int c_nch = DATA_W / CH_W;

  logic [DATA_W-1:0] w_bm;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  generate
    if (DATA_W == VRAM_DATA_W && CH_W == VRAM_CH_W) begin : g_pkg_mask
      assign w_bm = lane_mask(we);
    end else begin : g_lane_mask
      for (genvar i = 0; i < c_nch; i++) begin : g_lane
        assign w_bm[i*CH_W +: CH_W] = {CH_W{we[i]}};
      end
    end
  endgenerate

  // Array contents are intentionally never reset
  always_ff @(posedge clk) begin
    if (|we) begin
      r_mem[addr] <= (r_mem[addr] & ~w_bm) | (wdata & w_bm);
    end
    if (re) begin
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/vram_arb.sv
`default_nettype none
// ============================================================================
// Module  : vram_arb
// Brief   : Video RAM with display > fill > CPU arbitration; the fill engine and
//           clr_* ports exist only when VRAM_CLEAR_EN is defined.
// Revision: 1.0
// ============================================================================
module vram_arb
  import vram_pkg::*;
#(
  parameter int DATA_W = VRAM_DATA_W,
  parameter int CH_W   = VRAM_CH_W,
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DEPTH  = VRAM_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef VRAM_CLEAR_EN
  input  logic                    clr_start,
  input  logic [DATA_W-1:0]       clr_color,
  output logic                    clr_busy,
`endif
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  input  logic [DATA_W/CH_W-1:0]  cpu_wmask,
  output logic                    cpu_ack,
  output logic                    cpu_rvalid,
  output logic [DATA_W-1:0]       cpu_rdata,
  input  logic                    disp_re,
  input  logic [ADDR_W-1:0]       disp_addr,
  output logic                    disp_rvalid,
  output logic [DATA_W-1:0]       disp_rdata
);

  localparam int                c_nch       = DATA_W / CH_W;
  localparam int                c_idx_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   c_depth_ext = (ADDR_W+1)'(DEPTH);

  logic                w_disp_inr;
  logic                w_cpu_inr;
  logic                w_cpu_grant;
  logic                w_fill_busy;
  logic                w_fill_we;
  logic [ADDR_W-1:0]   w_fill_addr;
  logic [DATA_W-1:0]   w_fill_data;

  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic [c_nch-1:0]    w_mem_we;
  logic                w_mem_re;
  logic [DATA_W-1:0]   w_mem_rdata;

  logic                r_cpu_rv;
  logic                r_cpu_oor;
  logic [DATA_W-1:0]   r_cpu_hold;
  logic                r_disp_rv;
  logic                r_disp_oor;
  logic [DATA_W-1:0]   r_disp_hold;
  logic [DATA_W-1:0]   w_cpu_rdata;
  logic [DATA_W-1:0]   w_disp_rdata;

  assign w_disp_inr  = {1'b0, disp_addr} < c_depth_ext;
  assign w_cpu_inr   = {1'b0, cpu_addr}  < c_depth_ext;
  assign w_cpu_grant = rst_n && cpu_req && !disp_re && !w_fill_busy;
  assign cpu_ack     = w_cpu_grant;

`ifdef VRAM_CLEAR_EN
  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

  fill_state_t         r_state;
  fill_state_t         w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic [DATA_W-1:0]   r_color;
  logic [DATA_W-1:0]   w_color_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_color <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_color <= w_color_nxt;
    end
  end

  // The counter only advances on a write that actually reached the array
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_color_nxt = r_color;
    w_fill_we   = 1'b0;
    case (r_state)
      IDLE: begin
        if (clr_start) begin
          w_state_nxt = FILL;
          w_cnt_nxt   = '0;
          w_color_nxt = clr_color;
        end
      end
      FILL: begin
        if (!disp_re && rst_n) begin
          w_fill_we = 1'b1;
          if (r_cnt == c_last) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_fill_busy = (r_state == FILL);
  assign w_fill_addr = r_cnt;
  assign w_fill_data = r_color;
  assign clr_busy    = w_fill_busy;
`else
  assign w_fill_busy = 1'b0;
  assign w_fill_we   = 1'b0;
  assign w_fill_addr = '0;
  assign w_fill_data = '0;
`endif

  // One physical access per cycle: display, then fill, then CPU
  always_comb begin
    w_mem_addr  = cpu_addr;
    w_mem_wdata = cpu_wdata;
    w_mem_we    = '0;
    w_mem_re    = 1'b0;
    if (disp_re) begin
      w_mem_addr = disp_addr;
      w_mem_re   = w_disp_inr;
    end else if (w_fill_we) begin
      w_mem_addr  = w_fill_addr;
      w_mem_wdata = w_fill_data;
      w_mem_we    = '1;
    end else if (w_cpu_grant) begin
      if (cpu_we) begin
        w_mem_we = w_cpu_inr ? cpu_wmask : '0;
      end else begin
        w_mem_re = w_cpu_inr;
      end
    end
  end

  vram_mem #(
    .DATA_W (DATA_W),
    .CH_W   (CH_W),
    .DEPTH  (DEPTH),
    .IDX_W  (c_idx_w)
  ) u_mem (
    .clk    (clk),
    .re     (w_mem_re),
    .we     (w_mem_we),
    .addr   (w_mem_addr[c_idx_w-1:0]),
    .wdata  (w_mem_wdata),
    .rdata  (w_mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cpu_rv    <= 1'b0;
      r_cpu_oor   <= 1'b0;
      r_cpu_hold  <= '0;
      r_disp_rv   <= 1'b0;
      r_disp_oor  <= 1'b0;
      r_disp_hold <= '0;
    end else begin
      r_disp_rv  <= disp_re;
      r_disp_oor <= !w_disp_inr;
      r_cpu_rv   <= w_cpu_grant && !cpu_we;
      r_cpu_oor  <= !w_cpu_inr;
      if (r_cpu_rv) begin
        r_cpu_hold <= w_cpu_rdata;
      end
      if (r_disp_rv) begin
        r_disp_hold <= w_disp_rdata;
      end
    end
  end

  // Out-of-range reads return zero; data holds between valid pulses
  assign w_cpu_rdata  = r_cpu_oor  ? '0 : w_mem_rdata;
  assign w_disp_rdata = r_disp_oor ? '0 : w_mem_rdata;
  assign cpu_rvalid   = r_cpu_rv;
  assign disp_rvalid  = r_disp_rv;
  assign cpu_rdata    = r_cpu_rv  ? w_cpu_rdata  : r_cpu_hold;
  assign disp_rdata   = r_disp_rv ? w_disp_rdata : r_disp_hold;

endmodule
`default_nettype wire

// File: tb/tb_vram_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_vram_arb
// Brief   : Directed scoreboard bench for vram_arb; fill tests under VRAM_CLEAR_EN.
// Revision: 1.0
// ============================================================================
module tb_vram_arb;

  localparam int DATA_W = 12;
  localparam int CH_W   = 4;
  localparam int ADDR_W = 19;
  localparam int DEPTH  = 2048;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cpu_req;
  logic               cpu_we;
  logic [ADDR_W-1:0]  cpu_addr;
  logic [DATA_W-1:0]  cpu_wdata;
  logic [2:0]         cpu_wmask;
  logic               cpu_ack;
  logic               cpu_rvalid;
  logic [DATA_W-1:0]  cpu_rdata;
  logic               disp_re;
  logic [ADDR_W-1:0]  disp_addr;
  logic               disp_rvalid;
  logic [DATA_W-1:0]  disp_rdata;
`ifdef VRAM_CLEAR_EN
  logic               clr_start;
  logic [DATA_W-1:0]  clr_color;
  logic               clr_busy;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] model [int];
  logic [DATA_W-1:0] cpu_q [$];
  logic [DATA_W-1:0] disp_q [$];

  logic              cur_we;
  int                cur_addr;
  logic [DATA_W-1:0] cur_d;
  logic [2:0]        cur_m;

  int cyc;
  int busy_cnt;
  int early_ack;

  vram_arb #(
    .DATA_W (DATA_W),
    .CH_W   (CH_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef VRAM_CLEAR_EN
    .clr_start   (clr_start),
    .clr_color   (clr_color),
    .clr_busy    (clr_busy),
`endif
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_wmask   (cpu_wmask),
    .cpu_ack     (cpu_ack),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .disp_re     (disp_re),
    .disp_addr   (disp_addr),
    .disp_rvalid (disp_rvalid),
    .disp_rdata  (disp_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] expect_rd(input int a);
    return (a < DEPTH) ? model[a] : '0;
  endfunction

  // Apply the acked CPU access to the model, or queue its read result
  task automatic record();
    logic [DATA_W-1:0] v;
    if (cur_we) begin
      if (cur_addr < DEPTH) begin
        v = model.exists(cur_addr) ? model[cur_addr] : '0;
        for (int i = 0; i < 3; i++) begin
          if (cur_m[i]) v[i*CH_W +: CH_W] = cur_d[i*CH_W +: CH_W];
        end
        model[cur_addr] = v;
      end
    end else begin
      cpu_q.push_back(expect_rd(cur_addr));
    end
  endtask

  task automatic cpu_start(input logic we, input int a, input logic [DATA_W-1:0] d,
                           input logic [2:0] m);
    cur_we = we; cur_addr = a; cur_d = d; cur_m = m;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = ADDR_W'(a); cpu_wdata = d; cpu_wmask = m;
  endtask

  task automatic cpu_wait_ack(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!cpu_ack && n < 50) begin
      tick();
      @(negedge clk);
      n++;
    end
    check(tag, cpu_ack, 1'b1);
    if (cpu_ack) record();
  endtask

  task automatic cpu_op(input logic we, input int a, input logic [DATA_W-1:0] d,
                        input logic [2:0] m);
    tick();
    cpu_start(we, a, d, m);
    cpu_wait_ack("cpu_ack_timeout");
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic disp_read(input int a);
    tick();
    disp_re = 1'b1;
    disp_addr = ADDR_W'(a);
    disp_q.push_back(expect_rd(a));
    tick();
    disp_re = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cpu_rvalid) begin
      if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", cpu_rvalid, 1'b0);
      else check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
    end
    if (disp_rvalid) begin
      if (disp_q.size() == 0) check("disp_rvalid_unexpected", disp_rvalid, 1'b0);
      else check("disp_rdata", disp_rdata, disp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cpu_wmask = '0; disp_re = 1'b0; disp_addr = '0;
`ifdef VRAM_CLEAR_EN
    clr_start = 1'b0; clr_color = '0;
`endif
    repeat (3) tick();
    @(negedge clk);
    check("rst_cpu_ack", cpu_ack, 1'b0);
    check("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    check("rst_disp_rvalid", disp_rvalid, 1'b0);
    check("rst_cpu_rdata", cpu_rdata, 12'h000);
    check("rst_disp_rdata", disp_rdata, 12'h000);
`ifdef VRAM_CLEAR_EN
    check("rst_clr_busy", clr_busy, 1'b0);
`endif
    tick();
    cpu_req = 1'b0;
    rst_n = 1'b1;

    cpu_op(1'b1, 0, 12'h321, 3'b111);
    cpu_op(1'b1, 5, 12'h111, 3'b111);
    cpu_op(1'b1, 6, 12'h222, 3'b111);
    cpu_op(1'b1, 7, 12'h333, 3'b111);
    cpu_op(1'b1, DEPTH-1, 12'hDEF, 3'b111);

    // Display holds the array for three cycles while a CPU write waits
    tick();
    disp_re = 1'b1;
    cpu_start(1'b1, 5, 12'hABC, 3'b111);
    for (int c = 0; c < 3; c++) begin
      disp_addr = ADDR_W'(5 + c);
      disp_q.push_back(expect_rd(5 + c));
      @(negedge clk);
      check("prio_cpu_blocked", cpu_ack, 1'b0);
      tick();
    end
    disp_re = 1'b0;
    @(negedge clk);
    check("prio_ack_cycle4", cpu_ack, 1'b1);
    if (cpu_ack) record();
    tick();
    cpu_req = 1'b0;
    disp_read(5);

    // Lane masks
    cpu_op(1'b1, 10, 12'hFFF, 3'b111);
    cpu_op(1'b1, 10, 12'h123, 3'b010);
    cpu_op(1'b0, 10, 12'h000, 3'b000);
    @(negedge clk);
    tick();
    @(negedge clk);
    check("rvalid_single_pulse", cpu_rvalid, 1'b0);
    check("cpu_rdata_hold_F2F", cpu_rdata, 12'hF2F);
    cpu_op(1'b1, 10, 12'h777, 3'b000);
    cpu_op(1'b1, 10, 12'hABC, 3'b101);
    cpu_op(1'b0, 10, 12'h000, 3'b000);

    // A request left high after ack is served again
    tick();
    cpu_start(1'b0, 10, 12'h000, 3'b000);
    @(negedge clk);
    check("held_req_ack1", cpu_ack, 1'b1);
    if (cpu_ack) record();
    tick();
    cpu_start(1'b0, 5, 12'h000, 3'b000);
    @(negedge clk);
    check("held_req_ack2", cpu_ack, 1'b1);
    if (cpu_ack) record();
    tick();
    cpu_req = 1'b0;

    // Write acked at T is visible to a display read at T+1
    tick();
    cpu_start(1'b1, 100, 12'h5A5, 3'b111);
    cpu_wait_ack("wr_rd_ack");
    tick();
    cpu_req = 1'b0;
    disp_re = 1'b1;
    disp_addr = ADDR_W'(100);
    disp_q.push_back(12'h5A5);
    tick();
    disp_re = 1'b0;

    // Out-of-range accesses
    cpu_op(1'b1, DEPTH, 12'hFFF, 3'b111);
    cpu_op(1'b0, DEPTH, 12'h000, 3'b000);
    disp_read(DEPTH);
    cpu_op(1'b0, 0, 12'h000, 3'b000);
    disp_read(DEPTH-1);

`ifdef VRAM_CLEAR_EN
    tick();
    clr_start = 1'b1;
    clr_color = 12'h0F0;
    @(negedge clk);
    check("clr_busy_pre", clr_busy, 1'b0);
    tick();
    clr_start = 1'b0;
    cpu_start(1'b0, 0, 12'h000, 3'b000);
    for (int a = 0; a < DEPTH; a++) model[a] = 12'h0F0;
    busy_cnt = 0;
    early_ack = 0;
    cyc = 1;
    @(negedge clk);
    check("clr_busy_rise", clr_busy, 1'b1);
    while (clr_busy && cyc < DEPTH + 100) begin
      busy_cnt++;
      if (cpu_ack) early_ack++;
      tick();
      cyc++;
      disp_re = (cyc >= 50 && cyc < 60);
      disp_addr = '0;
      if (disp_re) disp_q.push_back(12'h0F0);
      clr_start = (cyc == 20);
      clr_color = (cyc == 20) ? 12'h00F : 12'h0F0;
      @(negedge clk);
    end
    check("clr_busy_cycles", busy_cnt, DEPTH + 10);
    check("fill_cpu_blocked", early_ack, 0);
    check("fill_cpu_ack_after", cpu_ack, 1'b1);
    if (cpu_ack) record();
    tick();
    cpu_req = 1'b0;
    disp_re = 1'b0;
    clr_start = 1'b0;
    cpu_op(1'b0, DEPTH-1, 12'h000, 3'b000);
    cpu_op(1'b0, 1234, 12'h000, 3'b000);

    // Reset while the counter sits at 1000
    cpu_op(1'b1, 999, 12'h111, 3'b111);
    cpu_op(1'b1, 1000, 12'h777, 3'b111);
    tick();
    clr_start = 1'b1;
    clr_color = 12'h0A0;
    tick();
    clr_start = 1'b0;
    repeat (1000) tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("busy_before_rst", clr_busy, 1'b1);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy_clear", clr_busy, 1'b0);
    check("rst_mid_cpu_rdata", cpu_rdata, 12'h000);
    for (int a = 0; a < 1000; a++) model[a] = 12'h0A0;
    cpu_op(1'b0, 999, 12'h000, 3'b000);
    cpu_op(1'b0, 1000, 12'h000, 3'b000);
    cpu_op(1'b0, 1001, 12'h000, 3'b000);
`endif

    repeat (3) tick();
    check("cpu_q_drained", cpu_q.size(), 0);
    check("disp_q_drained", disp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
